srrc_poly_tx_flt: RTL and testbench
===================================

SRRC_POLY_TX_FLT -- requirements
Module: srrc_poly_tx_flt

Interface
REQ-001 Parameter NUM_CH, default 2: independent symbol channels (1 = real PAM, 2 = I/Q); legal values 1..2.
REQ-002 Parameter OSR, default 4: samples per symbol; power of two, 2..16.
REQ-003 Parameter SPAN, default 20: filter span in symbols; impulse-response length is SPAN*OSR+1 taps.
REQ-004 Parameter COEF_W, default 18: signed coefficient width.
REQ-005 Parameter OUT_W, default 18: signed output sample width per channel.
REQ-006 Parameter OUT_SHIFT, default 2: arithmetic right shift from accumulator to output.
REQ-007 clk  input  1  single clock for the whole block.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 sam_clk_en  input  1  one-cycle sample strobe.
REQ-010 sym_clk_en  input  1  one-cycle symbol strobe; always coincides with a sam_clk_en.
REQ-011 sym_in  input  2*NUM_CH  2-bit symbol code per channel: 00=-3, 01=-1, 10=+1, 11=+3.
REQ-012 sym_valid  input  1  qualifies sym_in at sym_clk_en; if low, a zero symbol enters.
REQ-013 coef_we  input  1  coefficient write strobe.
REQ-014 coef_addr  input  clog2(SPAN*OSR+1)  coefficient index.
REQ-015 coef_din  input  COEF_W  signed coefficient value.
REQ-016 out  output  OUT_W*NUM_CH  filtered samples, channel 0 in the LSBs.
REQ-017 out_valid  output  1  one-cycle strobe marking a new out word.

Function
REQ-018 Phase counter: cleared to 0 on sym_clk_en; incremented modulo OSR on sam_clk_en otherwise; sym_clk_en wins when both strobes are high.
REQ-019 Symbol delay line: SPAN+1 entries per channel, each a 2-bit code plus a zero flag; shifts only on sym_clk_en; entry 0 takes sym_in or zero when sym_valid=0.
REQ-020 Tap k (0..SPAN) uses coefficient c[k*OSR+phase]; tap SPAN contributes only at phase 0, otherwise 0.
REQ-021 Products formed without multipliers: +-1 -> +-c, +-3 -> +-(2c+c); product width COEF_W+2; zero flag forces 0.
REQ-022 Accumulator width ACC_W = COEF_W+2+clog2(SPAN+1); no internal overflow.
REQ-023 Tap sums computed in a 3-stage registered adder tree running every clk; operands are sampled on the sam_clk_en cycle.
REQ-024 out updates and out_valid pulses exactly 4 clk cycles after the sam_clk_en that sampled the operands (latency 4, independent of parameters).
REQ-025 Output = (acc >>> OUT_SHIFT) reduced to OUT_W as per REQ-033/034.
REQ-026 Coefficient store: SPAN*OSR+1 registers; write on coef_we; coef_addr out of range ignored.
REQ-027 A write in the same cycle as sam_clk_en takes effect from the next sample; no partial-sample mixing.
REQ-028 Channels share coefficients and phase; they are arithmetically independent.
REQ-029 sam_clk_en gaps of any length are legal; the pipeline holds no state beyond in-flight samples.

Reset
REQ-030 On reset: out=0, out_valid=0, phase=0, all delay-line entries zero-flagged, pipeline registers 0.
REQ-031 Coefficient registers are NOT cleared by reset; they power up at 0 and retain values across reset.
REQ-032 Reset asserted mid-pipeline discards all in-flight samples; no out_valid for 4 cycles after reset deassertion unless new strobes arrive.

Configuration
REQ-033 Macro SRRC_TX_SAT_EN defined: shifted accumulator outside OUT_W range saturates to max positive / min negative.
REQ-034 Macro SRRC_TX_SAT_EN undefined: shifted accumulator truncated to its low OUT_W bits (two's-complement wrap).

Verification
REQ-035 Impulse: OSR=4, SPAN=4, OUT_SHIFT=0, c[n]=n+1; one +3 symbol then zeros -> outputs 3,6,9,...,51 over 17 samples, then 0.
REQ-036 sym_valid=0 at every symbol with arbitrary sym_in -> out stays 0 and out_valid still pulses every sam_clk_en.
REQ-037 Latency: single sam_clk_en at cycle t -> out_valid high only at t+4.
REQ-038 Coefficient rewrite c[0]=100 at a sam_clk_en cycle with +1 in tap 0, phase 0 -> new value appears only from the next phase-0 sample.
REQ-039 Overflow: all coefs max positive, all symbols +3, OUT_SHIFT=0 -> with SRRC_TX_SAT_EN out = 2^(OUT_W-1)-1; without it, low OUT_W bits of the exact sum.
REQ-040 Reset pulse 2 cycles after a sam_clk_en -> no out_valid from that sample; out=0 after reset.

Source files
------------

// File: rtl/srrc_poly_tx_flt.sv
`default_nettype none
// ============================================================================
// Module   : srrc_poly_tx_flt
// Desc     : Multiplier-free polyphase SRRC transmit filter, 4-cycle latency.
//            Define SRRC_TX_SAT_EN to saturate (instead of wrap) the output.
// Revision : 1.0  initial release
// ============================================================================
module srrc_poly_tx_flt #(
    parameter int NUM_CH    = 2,
    parameter int OSR       = 4,
    parameter int SPAN      = 20,
    parameter int COEF_W    = 18,
    parameter int OUT_W     = 18,
    parameter int OUT_SHIFT = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sam_clk_en,
    input  logic                              sym_clk_en,
    input  logic [2*NUM_CH-1:0]               sym_in,
    input  logic                              sym_valid,
    input  logic                              coef_we,
    input  logic [$clog2(SPAN*OSR+1)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]          coef_din,
    output logic [OUT_W*NUM_CH-1:0]           out,
    output logic                              out_valid
);
    localparam int c_NTAPS = SPAN*OSR + 1;
    localparam int c_AW    = $clog2(c_NTAPS);
    localparam int c_TAPS  = SPAN + 1;
    localparam int c_PH_W  = $clog2(OSR);
    localparam int c_PW    = COEF_W + 2;
    localparam int c_ACC_W = c_PW + $clog2(c_TAPS);
    localparam int c_NG1   = (c_TAPS + 3) / 4;
    localparam int c_NG2   = (c_NG1 + 3) / 4;
    localparam int c_P1    = 4 * c_NG1;
    localparam int c_P2    = 4 * c_NG2;
    localparam logic [c_AW:0] c_NTAPS_V = (c_AW+1)'(c_NTAPS);
`ifdef SRRC_TX_SAT_EN
    localparam int c_EXT_W = (c_ACC_W > OUT_W) ? c_ACC_W : OUT_W;
    localparam logic signed [c_EXT_W-1:0] c_SAT_MAX = {{(c_EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [c_EXT_W-1:0] c_SAT_MIN = {{(c_EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic signed [c_EXT_W-1:0] w_ext [NUM_CH];
`endif

    logic signed [COEF_W-1:0]  coef_q [c_NTAPS];
    logic signed [COEF_W-1:0]  coef_d [c_NTAPS];
    logic [c_PH_W-1:0]         phase_q, phase_d;
    logic [1:0]                code_q [NUM_CH][c_TAPS];
    logic [1:0]                code_d [NUM_CH][c_TAPS];
    logic                      zf_q   [NUM_CH][c_TAPS];
    logic                      zf_d   [NUM_CH][c_TAPS];
    logic signed [COEF_W-1:0]  w_tap_coef [c_TAPS];
    logic signed [c_PW-1:0]    prod_q [NUM_CH][c_P1];
    logic signed [c_PW-1:0]    prod_d [NUM_CH][c_P1];
    logic signed [c_ACC_W-1:0] sum1_q [NUM_CH][c_P2];
    logic signed [c_ACC_W-1:0] sum1_d [NUM_CH][c_P2];
    logic signed [c_ACC_W-1:0] sum2_q [NUM_CH][c_NG2];
    logic signed [c_ACC_W-1:0] sum2_d [NUM_CH][c_NG2];
    logic signed [c_ACC_W-1:0] w_acc   [NUM_CH];
    logic signed [c_ACC_W-1:0] w_shift [NUM_CH];
    logic [OUT_W-1:0]          w_res   [NUM_CH];
    logic [OUT_W*NUM_CH-1:0]   out_q, out_d;
    logic [3:0]                vld_q, vld_d;

    function automatic logic signed [c_PW-1:0] sym_mul(input logic [1:0] code,
                                                       input logic signed [COEF_W-1:0] coef);
        logic signed [c_PW-1:0] c1, c3;
        c1 = c_PW'(coef);
        c3 = (c1 <<< 1) + c1;
        case (code)
            2'b00:   sym_mul = -c3;
            2'b01:   sym_mul = -c1;
            2'b10:   sym_mul = c1;
            default: sym_mul = c3;
        endcase
    endfunction

    always_comb begin
        coef_d = coef_q;
        if (coef_we && ({1'b0, coef_addr} < c_NTAPS_V))
            coef_d[coef_addr] = coef_din;
    end

    always_comb begin
        phase_d = phase_q;
        if (sym_clk_en)
            phase_d = '0;
        else if (sam_clk_en)
            phase_d = phase_q + c_PH_W'(1);
    end

    always_comb begin
        code_d = code_q;
        zf_d   = zf_q;
        if (sym_clk_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int k = c_TAPS-1; k > 0; k--) begin
                    code_d[ch][k] = code_q[ch][k-1];
                    zf_d[ch][k]   = zf_q[ch][k-1];
                end
                code_d[ch][0] = sym_in[2*ch +: 2];
                zf_d[ch][0]   = ~sym_valid;
            end
        end
    end

    // Operands use the post-strobe phase/delay line so a new symbol hits tap 0 at phase 0,
    // but the pre-write coefficients so a same-cycle write only affects later samples.
    always_comb begin
        for (int k = 0; k < c_TAPS; k++) begin
            w_tap_coef[k] = '0;
            if (k < SPAN)
                w_tap_coef[k] = coef_q[c_AW'(k*OSR) + c_AW'(phase_d)];
            else if (phase_d == '0)
                w_tap_coef[k] = coef_q[c_NTAPS-1];
        end
    end

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int k = 0; k < c_P1; k++)
                prod_d[ch][k] = '0;
            for (int k = 0; k < c_TAPS; k++)
                prod_d[ch][k] = zf_d[ch][k] ? '0 : sym_mul(code_d[ch][k], w_tap_coef[k]);
        end
    end

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int g = 0; g < c_P2; g++)
                sum1_d[ch][g] = '0;
            for (int g = 0; g < c_NG1; g++)
                for (int j = 0; j < 4; j++)
                    sum1_d[ch][g] = sum1_d[ch][g] + c_ACC_W'(prod_q[ch][4*g+j]);
            for (int g = 0; g < c_NG2; g++) begin
                sum2_d[ch][g] = '0;
                for (int j = 0; j < 4; j++)
                    sum2_d[ch][g] = sum2_d[ch][g] + sum1_q[ch][4*g+j];
            end
        end
    end

    always_comb begin
        out_d = out_q;
        vld_d = {vld_q[2:0], sam_clk_en};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_acc[ch] = '0;
            for (int g = 0; g < c_NG2; g++)
                w_acc[ch] = w_acc[ch] + sum2_q[ch][g];
            w_shift[ch] = w_acc[ch] >>> OUT_SHIFT;
`ifdef SRRC_TX_SAT_EN
            w_ext[ch] = c_EXT_W'(w_shift[ch]);
            if (w_ext[ch] > c_SAT_MAX)
                w_res[ch] = c_SAT_MAX[OUT_W-1:0];
            else if (w_ext[ch] < c_SAT_MIN)
                w_res[ch] = c_SAT_MIN[OUT_W-1:0];
            else
                w_res[ch] = w_ext[ch][OUT_W-1:0];
`else
            w_res[ch] = OUT_W'(w_shift[ch]);
`endif
            if (vld_q[2])
                out_d[ch*OUT_W +: OUT_W] = w_res[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            out_q   <= '0;
            vld_q   <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int k = 0; k < c_TAPS; k++) begin
                    code_q[ch][k] <= '0;
                    zf_q[ch][k]   <= 1'b1;
                end
                for (int k = 0; k < c_P1; k++) prod_q[ch][k] <= '0;
                for (int g = 0; g < c_P2; g++) sum1_q[ch][g] <= '0;
                for (int g = 0; g < c_NG2; g++) sum2_q[ch][g] <= '0;
            end
        end else begin
            phase_q <= phase_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            code_q  <= code_d;
            zf_q    <= zf_d;
            prod_q  <= prod_d;
            sum1_q  <= sum1_d;
            sum2_q  <= sum2_d;
        end
    end

    // Coefficients deliberately survive reset.
    always_ff @(posedge clk) begin
        coef_q <= coef_d;
    end

    assign out       = out_q;
    assign out_valid = vld_q[3];

endmodule
`default_nettype wire

// File: tb/tb_srrc_poly_tx_flt.sv
`default_nettype none
// ============================================================================
// Module   : tb_srrc_poly_tx_flt
// Desc     : Scoreboard bench for srrc_poly_tx_flt against a convolution model.
// Revision : 1.0  initial release
// ============================================================================
module tb_srrc_poly_tx_flt;
    localparam int NUM_CH    = 2;
    localparam int OSR       = 4;
    localparam int SPAN      = 4;
    localparam int COEF_W    = 18;
    localparam int OUT_W     = 18;
    localparam int OUT_SHIFT = 0;
    localparam int NTAPS     = SPAN*OSR + 1;
    localparam int AW        = $clog2(NTAPS);
    localparam int SW        = 2*NUM_CH;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     sam_clk_en = 1'b0;
    logic                     sym_clk_en = 1'b0;
    logic [SW-1:0]            sym_in = '0;
    logic                     sym_valid = 1'b0;
    logic                     coef_we = 1'b0;
    logic [AW-1:0]            coef_addr = '0;
    logic signed [COEF_W-1:0] coef_din = '0;
    logic [OUT_W*NUM_CH-1:0]  out;
    logic                     out_valid;

    srrc_poly_tx_flt #(
        .NUM_CH(NUM_CH), .OSR(OSR), .SPAN(SPAN),
        .COEF_W(COEF_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .sym_in(sym_in), .sym_valid(sym_valid), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_din(coef_din), .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                      due;
        logic [OUT_W*NUM_CH-1:0] data;
    } exp_t;

    exp_t   exp_q[$];
    longint m_coef [NTAPS];
    int     m_hist [NUM_CH][SPAN+1];
    int     m_phase = 0;
    int     errors = 0;
    int     checks = 0;

    function automatic logic [OUT_W-1:0] reduce(input longint acc);
        longint s;
        s = acc >>> OUT_SHIFT;
`ifdef SRRC_TX_SAT_EN
        if (s > (longint'(1) <<< (OUT_W-1)) - 1)
            s = (longint'(1) <<< (OUT_W-1)) - 1;
        else if (s < -(longint'(1) <<< (OUT_W-1)))
            s = -(longint'(1) <<< (OUT_W-1));
`endif
        return s[OUT_W-1:0];
    endfunction

    // y[n] = sum_k sym[k] * h[k*OSR + phase], h taken from the current model coefficients
    function automatic logic [OUT_W*NUM_CH-1:0] model_sample();
        logic [OUT_W*NUM_CH-1:0] w;
        longint acc;
        int     idx;
        w = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            acc = 0;
            for (int k = 0; k <= SPAN; k++) begin
                idx = k*OSR + m_phase;
                if (idx < NTAPS)
                    acc = acc + longint'(m_hist[ch][k]) * m_coef[idx];
            end
            w[ch*OUT_W +: OUT_W] = reduce(acc);
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input bit sam, input bit sym, input bit vld, input logic [SW-1:0] si,
                         input bit we, input logic [AW-1:0] addr, input logic [COEF_W-1:0] din);
        exp_t e;
        @(posedge clk);
        #2;
        sam_clk_en = sam; sym_clk_en = sym; sym_valid = vld; sym_in = si;
        coef_we = we; coef_addr = addr; coef_din = din;
        if (sym) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int k = SPAN; k > 0; k--)
                    m_hist[ch][k] = m_hist[ch][k-1];
                m_hist[ch][0] = vld ? 2*int'(si[2*ch +: 2]) - 3 : 0;
            end
            m_phase = 0;
        end else if (sam) begin
            m_phase = (m_phase + 1) % OSR;
        end
        if (sam) begin
            e.due  = cyc + 4;
            e.data = model_sample();
            exp_q.push_back(e);
        end
        if (we && int'(addr) < NTAPS)
            m_coef[addr] = longint'($signed(din));
    endtask

    task automatic step(input bit sam, input bit sym, input bit vld, input logic [SW-1:0] si,
                        input int wr_pct);
        bit we;
        we = ($urandom_range(99, 0) < wr_pct);
        drive(sam, sym, vld, si, we, AW'($urandom_range(31, 0)), COEF_W'($urandom));
    endtask

    task automatic send_symbol(input bit vld, input logic [SW-1:0] si,
                               input int gap_max, input int wr_pct);
        int g;
        for (int p = 0; p < OSR; p++) begin
            g = $urandom_range(gap_max, 0);
            repeat (g) step(1'b0, 1'b0, 1'b0, SW'($urandom), wr_pct);
            step(1'b1, p == 0, vld, si, wr_pct);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, SW'($urandom), 1'b0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2;
        reset = 1'b1; sam_clk_en = 1'b0; sym_clk_en = 1'b0; coef_we = 1'b0;
        // samples that would surface after reset is sampled are discarded
        while (exp_q.size() > 0 && exp_q[$].due > cyc)
            void'(exp_q.pop_back());
        m_phase = 0;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int k = 0; k <= SPAN; k++)
                m_hist[ch][k] = 0;
        repeat (n) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: cyc %0d out %h, required no output", cyc, out);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.due != cyc || out !== mon_e.data) begin
                    errors++;
                    $display("FAIL sample: cyc %0d out %h, required cyc %0d out %h",
                             cyc, out, mon_e.due, mon_e.data);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checks++;
            errors++;
            mon_e = exp_q.pop_front();
            $display("FAIL missing_out_valid: cyc %0d no output, required out %h at cyc %0d",
                     cyc, mon_e.data, mon_e.due);
        end
    end

    initial begin
        for (int n = 0; n < NTAPS; n++) m_coef[n] = 0;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int k = 0; k <= SPAN; k++) m_hist[ch][k] = 0;

        do_reset(3);
        @(negedge clk);
        check("reset_out", 64'(out), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);

        // impulse: c[n]=n+1, ch0 +3, ch1 -1, then zero symbols
        for (int n = 0; n < NTAPS; n++)
            drive(1'b0, 1'b0, 1'b0, '0, 1'b1, AW'(n), COEF_W'(n + 1));
        send_symbol(1'b1, 4'b0111, 0, 0);
        repeat (6) send_symbol(1'b0, SW'($urandom), 0, 0);

        // invalid symbols with arbitrary codes and strobe gaps
        repeat (4) send_symbol(1'b0, SW'($urandom), 3, 0);

        // c[0] rewritten on the phase-0 strobe that brings +1 into tap 0
        drive(1'b1, 1'b1, 1'b1, 4'b1010, 1'b1, '0, COEF_W'(100));
        repeat (OSR-1) drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        send_symbol(1'b1, 4'b1010, 1, 0);
        repeat (5) send_symbol(1'b0, '0, 0, 0);

        // random symbols, gaps and coefficient writes (incl. out-of-range)
        repeat (30) send_symbol($urandom_range(9, 0) < 8, SW'($urandom), 2, 10);
        idle(8);

        // overflow: max coefficients, ch0 +3, ch1 -3
        for (int n = 0; n < NTAPS; n++)
            drive(1'b0, 1'b0, 1'b0, '0, 1'b1, AW'(n), {1'b0, {(COEF_W-1){1'b1}}});
        repeat (6) send_symbol(1'b1, 4'b0011, 0, 0);
        idle(6);

        // reset two cycles after a strobe: that sample must never appear
        drive(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, '0, '0);
        idle(1);
        do_reset(2);
        @(negedge clk);
        check("mid_reset_out", 64'(out), 64'd0);
        check("mid_reset_valid", 64'(out_valid), 64'd0);
        idle(10);

        // coefficients retained across reset
        send_symbol(1'b1, 4'b1100, 1, 0);
        repeat (6) send_symbol(1'b0, '0, 1, 0);

        for (int t = 0; t < 50 && exp_q.size() > 0; t++)
            @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
